// File: rtl/laplace_line_feeder.sv
// Line-buffer feeder for the Laplace filter core: holds a rolling window of image lines,
// replays three consecutive lines per output row, and forwards the core's filtered results.
module laplace_line_feeder #(
  parameter int LINE_WORDS = 64,
  parameter int SLOTS      = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_img_valid,
  input  logic [63:0] i_img_data,
  output logic        o_img_ack,
  output logic        o_line1_valid,
  output logic [63:0] o_line1_data,
  output logic        o_line2_valid,
  output logic [63:0] o_line2_data,
  output logic        o_line3_valid,
  output logic [63:0] o_line3_data,
  output logic        o_filter,
  input  logic        i_res_valid,
  input  logic [63:0] i_res_data,
  output logic        o_res_ack,
  output logic        o_out_valid,
  output logic [63:0] o_out_data,
  input  logic        i_out_ack
);
  localparam int DATA_W = 64;
  localparam int IDX_W  = $clog2(LINE_WORDS);
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int OCC_W  = $clog2(SLOTS + 1);
  localparam int CNT_W  = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_FILTER, S_GAP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_mem [SLOTS*LINE_WORDS];
  logic [SLOT_W-1:0]   r_wr_slot;
  logic [IDX_W-1:0]    r_wr_idx;
  logic [OCC_W-1:0]    r_occ;
  logic [SLOT_W-1:0]   r_base;
  logic [IDX_W-1:0]    r_rd_idx;
  logic [CNT_W-1:0]    r_res_cnt;
  logic                r_gap_cnt;
  logic                r_vld_p1;
  logic [DATA_W-1:0]   r_line1_p1;
  logic [DATA_W-1:0]   r_line2_p1;
  logic [DATA_W-1:0]   r_line3_p1;
  logic                r_filter;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_data;

  logic                w_img_acc;
  logic                w_line_done;
  logic                w_res_pop;
  logic                w_last_pop;
  logic [SLOT_W-1:0]   w_slot1;
  logic [SLOT_W-1:0]   w_slot2;
  logic [SLOT_W-1:0]   w_slot3;

  assign o_img_ack   = (r_occ < OCC_W'(SLOTS));
  assign w_img_acc   = i_rst & i_img_valid & o_img_ack;
  assign w_line_done = w_img_acc & (r_wr_idx == IDX_W'(LINE_WORDS - 1));

  // Pops are gated by reset so no result is lost while the core is also held in reset.
  assign o_res_ack  = i_rst & i_res_valid & (~r_out_valid | i_out_ack);
  assign w_res_pop  = o_res_ack;
  assign w_last_pop = (r_state == S_FILTER) & w_res_pop & (r_res_cnt == CNT_W'(LINE_WORDS - 1));

  // Slot indices wrap naturally because SLOTS is a power of two.
  assign w_slot1 = r_base;
  assign w_slot2 = r_base + SLOT_W'(1);
  assign w_slot3 = r_base + SLOT_W'(2);

  assign o_line1_valid = r_vld_p1;
  assign o_line2_valid = r_vld_p1;
  assign o_line3_valid = r_vld_p1;
  assign o_line1_data  = r_line1_p1;
  assign o_line2_data  = r_line2_p1;
  assign o_line3_data  = r_line3_p1;
  assign o_filter      = r_filter;
  assign o_out_valid   = r_out_valid;
  assign o_out_data    = r_out_data;

  always_ff @(posedge i_clk) begin
    if (w_img_acc) begin
      r_mem[{r_wr_slot, r_wr_idx}] <= i_img_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (r_occ >= OCC_W'(3)) w_state_nxt = S_SEND;
      S_SEND:   if (r_rd_idx == IDX_W'(LINE_WORDS - 1)) w_state_nxt = S_FILTER;
      S_FILTER: if (w_last_pop) w_state_nxt = S_GAP;
      S_GAP:    if (r_gap_cnt) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_wr_slot   <= '0;
      r_wr_idx    <= '0;
      r_occ       <= '0;
      r_base      <= '0;
      r_rd_idx    <= '0;
      r_res_cnt   <= '0;
      r_gap_cnt   <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_filter    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_img_acc) r_wr_idx <= r_wr_idx + IDX_W'(1);
      if (w_line_done) r_wr_slot <= r_wr_slot + SLOT_W'(1);

      // A line completing in the same cycle the oldest line retires leaves occupancy unchanged.
      case ({w_line_done, w_last_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase

      if (w_last_pop) r_base <= r_base + SLOT_W'(1);

      if (r_state == S_SEND) r_rd_idx <= r_rd_idx + IDX_W'(1);
      else                   r_rd_idx <= '0;

      if (w_last_pop)                           r_res_cnt <= '0;
      else if ((r_state == S_FILTER) && w_res_pop) r_res_cnt <= r_res_cnt + CNT_W'(1);

      if (r_state == S_GAP) r_gap_cnt <= ~r_gap_cnt;
      else                  r_gap_cnt <= 1'b0;

      // Filter request trails the last line word by one cycle and drops as the last result pops.
      r_vld_p1 <= (r_state == S_SEND);
      r_filter <= (r_state == S_FILTER) & ~w_last_pop;

      if (w_res_pop)      r_out_valid <= 1'b1;
      else if (i_out_ack) r_out_valid <= 1'b0;
    end
  end

  // ---- p1: registered line reads and result holding register ----
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_line1_p1 <= '0;
      r_line2_p1 <= '0;
      r_line3_p1 <= '0;
      r_out_data <= '0;
    end else begin
      if (r_state == S_SEND) begin
        r_line1_p1 <= r_mem[{w_slot1, r_rd_idx}];
        r_line2_p1 <= r_mem[{w_slot2, r_rd_idx}];
        r_line3_p1 <= r_mem[{w_slot3, r_rd_idx}];
      end
      if (w_res_pop) r_out_data <= i_res_data;
    end
  end

endmodule
